// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared types, constants and anode helper for the seven-segment scan driver
package ssd_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam int DEFAULT_DIGITS = 4;

    // One bit of the active-low one-hot anode pattern: low only at the selected digit.
    function automatic logic anode_low(input int unsigned idx, input int unsigned bit_pos);
        return (idx != bit_pos);
    endfunction

endpackage

// File: rtl/ssd_lz_mask.sv
// rtl/ssd_lz_mask.sv - per-digit leading-zero blank mask
module ssd_lz_mask
    import ssd_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic [4*DIGITS-1:4] upper,
    input  logic                blank_lz,
    output logic [DIGITS-1:0]   mask
);

    logic zero_above;

    // Walk down from the top digit; a digit is blanked while every nibble at or above it is zero.
    always_comb begin
        mask       = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above & (upper[4*i +: 4] == 4'h0);
            mask[i]    = blank_lz & zero_above;
        end
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - time-multiplexed common-anode seven-segment scan driver
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int DIGITS          = DEFAULT_DIGITS,
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int GUARD_TICKS     = 500
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*DIGITS-1:0]       value,
    input  logic                      blank_lz,
    output logic [3:0]                nibble,
    output logic [DIGITS-1:0]         an_n,
    output logic [$clog2(DIGITS)-1:0] digit_idx,
    output logic                      frame_done
);

    localparam int IW        = $clog2(DIGITS);
    localparam int MAX_TICKS = (TICKS_PER_DIGIT > GUARD_TICKS) ? TICKS_PER_DIGIT : GUARD_TICKS;
    localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(TICKS_PER_DIGIT - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_TICKS - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);

    scan_state_t         state, state_d;
    logic [CW-1:0]       tick, tick_d;
    logic [IW-1:0]       idx_d;
    logic                boundary;
    logic [4*DIGITS-1:0] disp, disp_d;
    logic [4*DIGITS-1:0] pending, pending_d;
    logic                pend_v, pend_v_d;
    logic [3:0]          nibble_d;
    logic [DIGITS-1:0]   an_n_d;
    logic                frame_done_d;
    logic [DIGITS-1:0]   blank_mask;

    ssd_lz_mask #(
        .DIGITS (DIGITS)
    ) u_lz_mask (
        .upper    (disp[4*DIGITS-1:4]),
        .blank_lz (blank_lz),
        .mask     (blank_mask)
    );

    // State, counters, value registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GUARD;
            tick       <= '0;
            digit_idx  <= LAST_IDX;
            disp       <= '0;
            pending    <= '0;
            pend_v     <= 1'b0;
            nibble     <= 4'h0;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            tick       <= tick_d;
            digit_idx  <= idx_d;
            disp       <= disp_d;
            pending    <= pending_d;
            pend_v     <= pend_v_d;
            nibble     <= nibble_d;
            an_n       <= an_n_d;
            frame_done <= frame_done_d;
        end
    end

    // Scan sequencing: guard/show alternation, tick counting and digit advance.
    always_comb begin
        state_d  = state;
        tick_d   = tick + 1'b1;
        idx_d    = digit_idx;
        boundary = 1'b0;
        case (state)
            GUARD: begin
                if (tick == GUARD_LAST) begin
                    state_d  = SHOW;
                    tick_d   = '0;
                    boundary = (digit_idx == LAST_IDX);
                    idx_d    = (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
                end
            end
            SHOW: begin
                if (tick == SHOW_LAST) begin
                    state_d = GUARD;
                    tick_d  = '0;
                end
            end
            default: begin
                state_d = GUARD;
                tick_d  = '0;
            end
        endcase
    end

    // Value staging: loads wait in pending until the frame boundary; a load on the boundary goes straight in.
    always_comb begin
        disp_d    = disp;
        pending_d = pending;
        pend_v_d  = pend_v;
        if (load) begin
            pending_d = value;
            pend_v_d  = 1'b1;
        end
        if (boundary) begin
            if (load) begin
                disp_d = value;
            end else if (pend_v) begin
                disp_d = pending;
            end
            pend_v_d = 1'b0;
        end
    end

    // Next output values: nibble latched on digit entry, anode driven only in an unblanked show slot.
    always_comb begin
        nibble_d     = nibble;
        an_n_d       = '1;
        frame_done_d = boundary;
        if (state == GUARD && state_d == SHOW) begin
            nibble_d = disp_d[4*idx_d +: 4];
        end
        if (state_d == SHOW && !blank_mask[idx_d]) begin
            for (int i = 0; i < DIGITS; i++) begin
                an_n_d[i] = anode_low(int'(idx_d), i);
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - self-checking bench for ssd_scan_driver
module tb_ssd_scan_driver;

    localparam int D = 4;
    localparam int T = 4;
    localparam int G = 1;
    localparam int P = T + G;
    localparam int F = D * P;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        load     = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] value    = 16'h0;
    logic [3:0]  nibble;
    logic [3:0]  an_n;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    int          k      = 0;
    logic [15:0] latest = 16'h0;
    logic [15:0] mdisp  = 16'h0;
    int          r_m, d_m, s_m;
    logic [3:0]  e_nib, e_an;
    logic [1:0]  e_idx;
    logic        e_fd;
    logic        model_on = 1'b0;
    int          cnt;

    ssd_scan_driver #(
        .DIGITS          (D),
        .TICKS_PER_DIGIT (T),
        .GUARD_TICKS     (G)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .nibble     (nibble),
        .an_n       (an_n),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic lit(input string name, input logic [3:0] an, input logic [3:0] nib);
        chk({name, "_an"}, 32'(an_n), 32'(an));
        chk({name, "_nib"}, 32'(nibble), 32'(nib));
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (k < target && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("run_to", k, target);
    endtask

    task automatic do_load(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Frame-level model: edge k after reset maps to frame/slot/phase; the shown value is the
    // latest load seen at or before the frame's first edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            k      = 0;
            latest = 16'h0;
            mdisp  = 16'h0;
        end else begin
            k++;
            if (load) latest = value;
            if ((k - 1) % F == 0) mdisp = latest;
        end
        if (k == 0) begin
            e_idx = 2'(D - 1);
            e_an  = 4'hF;
            e_nib = 4'h0;
            e_fd  = 1'b0;
        end else begin
            r_m   = (k - 1) % F;
            d_m   = r_m / P;
            s_m   = r_m % P;
            e_idx = 2'(d_m);
            e_nib = mdisp[4*d_m +: 4];
            e_fd  = (r_m == 0);
            if (s_m < T && !(blank_lz && d_m > 0 && (mdisp >> (4*d_m)) == 16'h0))
                e_an = ~(4'b0001 << d_m);
            else
                e_an = 4'hF;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n && model_on) begin
            chk("m_an", 32'(an_n), 32'(e_an));
            chk("m_nib", 32'(nibble), 32'(e_nib));
            chk("m_idx", 32'(digit_idx), 32'(e_idx));
            chk("m_fd", 32'(frame_done), 32'(e_fd));
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an_n), 32'hF);
        chk("rst_nib", 32'(nibble), 32'h0);
        chk("rst_idx", 32'(digit_idx), 32'h3);
        chk("rst_fd", 32'(frame_done), 32'h0);

        load     = 1'b1;
        value    = 16'h1234;
        rst_n    = 1'b1;
        model_on = 1'b1;
        @(negedge clk);
        load = 1'b0;
        lit("scan0", 4'b1110, 4'h4);
        chk("scan0_fd", 32'(frame_done), 32'h1);
        chk("scan0_idx", 32'(digit_idx), 32'h0);
        run_to(5);   lit("guard0", 4'b1111, 4'h4);
        run_to(6);   lit("scan1", 4'b1101, 4'h3);
        run_to(11);  lit("scan2", 4'b1011, 4'h2);
        run_to(12);  do_load(16'hABCD);
        run_to(16);  lit("old3", 4'b0111, 4'h1);
        run_to(21);  lit("new0", 4'b1110, 4'hD);
        chk("new0_fd", 32'(frame_done), 32'h1);
        run_to(26);  lit("new1", 4'b1101, 4'hC);

        run_to(28);  do_load(16'h1111);
        run_to(33);  do_load(16'h2222);
        run_to(41);  lit("ovw0", 4'b1110, 4'h2);
        run_to(46);  lit("ovw1", 4'b1101, 4'h2);

        run_to(60);  do_load(16'h5678);
        lit("coin0", 4'b1110, 4'h8);
        chk("coin0_fd", 32'(frame_done), 32'h1);
        run_to(76);  lit("coin3", 4'b0111, 4'h5);

        blank_lz = 1'b1;
        run_to(79);  do_load(16'h0070);
        run_to(81);  lit("lz70_d0", 4'b1110, 4'h0);
        run_to(86);  lit("lz70_d1", 4'b1101, 4'h7);
        run_to(91);  lit("lz70_d2", 4'b1111, 4'h0);
        run_to(96);  lit("lz70_d3", 4'b1111, 4'h0);
        run_to(99);  do_load(16'h0000);
        run_to(101); lit("lz0_d0", 4'b1110, 4'h0);
        run_to(106); lit("lz0_d1", 4'b1111, 4'h0);
        run_to(111); lit("lz0_d2", 4'b1111, 4'h0);
        run_to(116); lit("lz0_d3", 4'b1111, 4'h0);
        blank_lz = 1'b0;
        run_to(117); lit("lz_off", 4'b0111, 4'h0);

        run_to(121);
        chk("period_start", 32'(frame_done), 32'h1);
        for (int f = 0; f < 10; f++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!frame_done && cnt < 100);
            chk("period", cnt, 20);
        end

        do_load(16'h9999);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", 32'(an_n), 32'hF);
        chk("async_nib", 32'(nibble), 32'h0);
        chk("async_idx", 32'(digit_idx), 32'h3);
        chk("async_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_fd", 32'(frame_done), 32'h1);
        lit("rel0", 4'b1110, 4'h0);
        run_to(6);   lit("rel1", 4'b1101, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Time-multiplexed scan driver for a common-anode multi-digit seven-segment display. Holds a hex value, walks the digits at a programmable refresh rate, and presents one 4-bit nibble per slot to the downstream hex-to-segment decoder (`nibble` feeds its 4-bit input) together with active-low digit enables. Inserts a ghost-suppression guard interval between digits, optionally blanks leading zeros, and updates the displayed value only at frame boundaries so digits never tear.

## Interface
- `DIGITS`, 4: number of digits scanned; range 2–8.
- `TICKS_PER_DIGIT`, 50000: clocks each digit is lit; must be ≥ 1.
- `GUARD_TICKS`, 500: clocks with all anodes off between digits; must be ≥ 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  single-cycle strobe; captures `value`.
- `value`  in  4*DIGITS  hex value; nibble i = `value[4i+3:4i]`, digit 0 = least significant.
- `blank_lz`  in  1  1 = suppress leading zero digits.
- `nibble`  out  4  hex digit to the segment decoder.
- `an_n`  out  DIGITS  active-low digit enables; at most one bit low.
- `digit_idx`  out  clog2(DIGITS)  index of the current slot.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation
- Registers: `disp` (shown value), `pending` plus `pend_v`, state, `tick` counter, `digit_idx`.
- States: GUARD (all anodes off) and SHOW (one anode on).
- GUARD: `tick` counts 0..GUARD_TICKS-1. On the last tick, go to SHOW, set `tick`=0, and advance `digit_idx` (DIGITS-1 wraps to 0).
- SHOW: `tick` counts 0..TICKS_PER_DIGIT-1. On the last tick, go to GUARD and set `tick`=0.
- Frame boundary is the GUARD→SHOW edge where `digit_idx` wraps to 0. On that edge:
  - `frame_done` pulses.
  - If `pend_v`, then `disp`←`pending` and `pend_v`←0.
- `load` sets `pending`←`value` and `pend_v`←1. A later load before the boundary overwrites `pending`; the last value wins.
- If `load` coincides with the boundary edge, `value` bypasses directly into `disp` and `pend_v` ends at 0.
- `nibble` = `disp[4*idx +: 4]` for the digit being entered. It is registered and updated on the same edge as `digit_idx`, and held through GUARD.
- `an_n` in SHOW is ~(1<<idx), unless the slot is blanked. In GUARD, `an_n` is all ones.
- Leading-zero blank: with `blank_lz`=1, digit i>0 is blanked when nibbles i..DIGITS-1 of `disp` are all zero. A blanked digit's slot keeps full timing with `an_n` all ones. Digit 0 is never blanked, so value 0 shows a single "0".
- `blank_lz` is sampled each cycle with no latching.
- Reset (asynchronous, immediate):
  - Outputs: `an_n` all ones, `nibble`=0, `frame_done`=0, `digit_idx`=DIGITS-1.
  - Internal: state GUARD, `tick`=0, `disp`=0, `pending`=0, `pend_v`=0.
  - Reset mid-frame discards the displayed and pending values.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- After `rst_n` rises, the first GUARD lasts GUARD_TICKS clocks. Then `an_n`=~1 and `frame_done`=1 appear together, for digit 0.
- Each digit is lit for exactly TICKS_PER_DIGIT clocks and dark for exactly GUARD_TICKS clocks.
- Frame period is DIGITS*(TICKS_PER_DIGIT+GUARD_TICKS) clocks.
- `frame_done` is high for exactly 1 clock per frame.
- Load-to-display latency is at most one frame period plus 1 clock. A `disp` change is first visible on digit 0 at the boundary.
- Counter width is clog2(max(TICKS_PER_DIGIT, GUARD_TICKS)). The counter compares to limit−1 and never wraps freely.

## Structure
- Shared package `ssd_pkg` holds:
  - the scan state enum {GUARD, SHOW};
  - the default DIGITS constant;
  - a helper function for the active-low one-hot anode pattern.
- Optional combinational sub-module `ssd_lz_mask`: `disp` in → per-digit blank mask out.
- The top level instantiates the existing segment decoder externally. This block does not include it.

## Test plan
Bench parameters: DIGITS=4, TICKS_PER_DIGIT=4, GUARD_TICKS=1 (frame = 20 clocks).
- Scan sequence: reset, `load` 0x1234 → `an_n` cycles 1110, 1101, 1011, 0111. Each is held 4 clocks, with 1 clock of 1111 between them. `nibble` reads 4, 3, 2, 1.
- Reset values: assert `rst_n`=0 mid-SHOW → `an_n`=1111, `nibble`=0, `digit_idx`=3 immediately, with no clock. After release, `frame_done` pulses on clock 1.
- Frame-aligned update: `load` 0xABCD while digit 2 is lit → digits 2–3 still show the old value. At the next boundary, digit 0 shows D with `frame_done`=1.
- Coincident and overwrite loads:
  - `load` 0x1111 then 0x2222 in one frame → only 2222 is displayed.
  - `load` on the boundary clock → that value shows on the same frame.
- Leading-zero blanking with `blank_lz`=1:
  - value 0x0070 → digits 3 and 2 have `an_n` all ones; digits 1 and 0 are lit.
  - value 0x0000 → only digit 0 is lit.
- Period check: `frame_done` pulses are exactly 20 clocks apart over 10 frames.
